// File: rtl/bc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bc_pkg
// Description : Shared definitions for the Bulls-and-Cows datapath: digit
//               geometry, the input front-end state type, the packed guess
//               type and the reusable digit-validity check.
// Revision    : 1.0 - initial release
// ============================================================================
package bc_pkg;

    localparam int             NUM_DIGITS = 4;
    localparam int             DIGIT_W    = 4;
    localparam logic [3:0]     MAX_DIGIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CHECK        = 2'd1,
        OFFER        = 2'd2,
        WAIT_RELEASE = 2'd3
    } entrada_state_t;

    typedef logic [NUM_DIGITS*DIGIT_W-1:0] guess_t;

    // An entry is usable only when every nibble is a decimal digit and no
    // digit appears twice. Pure combinational, so the game core can apply the
    // same rule to the secret.
    function automatic logic digits_valid(input guess_t g);
        logic               ok;
        logic [DIGIT_W-1:0] di;
        logic [DIGIT_W-1:0] dj;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            di = g[i*DIGIT_W +: DIGIT_W];
            if (di > MAX_DIGIT) begin
                ok = 1'b0;
            end
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                dj = g[j*DIGIT_W +: DIGIT_W];
                if (di == dj) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage : bc_pkg
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module      : debouncer
// Description : Two-flop synchronizer plus counter-based debouncer for a raw
//               push-button. A level change is accepted only after the
//               synchronized input has differed from the stable level for
//               DEBOUNCE_CYCLES consecutive cycles.
// Ports       : clock - system clock (rising edge)
//               reset - synchronous, active-low reset
//               raw   - asynchronous button input
//               level - debounced stable level
//               rise  - one-cycle pulse when level goes 0 -> 1
// Revision    : 1.0 - initial release
// ============================================================================
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000   // must be >= 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while the synchronized input disagrees with the
    // stable level; any bounce back to agreement restarts the qualification.
    // The rise pulse is registered alongside the level update, so it is high
    // in exactly the cycle in which the new level first appears.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_rise <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule : debouncer
`default_nettype wire

// File: rtl/entrada_jogada.sv
`default_nettype none
// ============================================================================
// Module      : entrada_jogada
// Description : Input front-end for Bulls-and-Cows. Debounces the enter
//               button, synchronizes the switch digits, validates one
//               captured entry per press and offers it to the game core on a
//               valid/ready handshake. Rejected entries produce a one-cycle
//               error pulse.
// Ports       : clock        - system clock (rising edge)
//               reset        - synchronous, active-low reset
//               enter_button - raw push-button
//               SW[15:0]     - raw switches, SW[15:12] is the leftmost digit
//               guess_ready  - game core accepts a guess
//               guess_valid  - guess holds a validated value
//               guess[15:0]  - captured digits, same layout as SW
//               guess_err    - one-cycle pulse on a rejected entry
// Revision    : 1.0 - initial release
// ============================================================================
module entrada_jogada
    import bc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enter_button,
    input  logic [15:0] SW,
    input  logic        guess_ready,
    output logic        guess_valid,
    output logic [15:0] guess,
    output logic        guess_err
);

    logic           w_level;
    logic           w_press;
    logic           w_snap_ok;

    guess_t         r_sw_s1;
    guess_t         r_sw_s2;
    guess_t         r_snap;
    guess_t         r_guess;
    logic           r_guess_valid;
    logic           r_guess_err;
    entrada_state_t r_state;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock (clock),
        .reset (reset),
        .raw   (enter_button),
        .level (w_level),
        .rise  (w_press)
    );

    // Switches are slow but still asynchronous; each bit gets its own pair
    // of flops. Bit-wise skew is harmless because the snapshot is taken
    // thousands of cycles after the switches have settled.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
        end
    end

    assign w_snap_ok = digits_valid(r_snap);

    // Presses are consumed only in IDLE, so a press that lands while an
    // entry is being checked, offered or released simply vanishes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_snap        <= '0;
            r_guess       <= '0;
            r_guess_valid <= 1'b0;
            r_guess_err   <= 1'b0;
        end else begin
            r_guess_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        r_snap  <= r_sw_s2;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_snap_ok) begin
                        r_guess       <= r_snap;
                        r_guess_valid <= 1'b1;
                        r_state       <= OFFER;
                    end else begin
                        r_guess_err <= 1'b1;
                        r_state     <= WAIT_RELEASE;
                    end
                end
                OFFER: begin
                    // guess keeps its value after the transfer; only the
                    // valid flag drops.
                    if (guess_ready) begin
                        r_guess_valid <= 1'b0;
                        r_state       <= w_level ? WAIT_RELEASE : IDLE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!w_level) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign guess_valid = r_guess_valid;
    assign guess       = r_guess;
    assign guess_err   = r_guess_err;

endmodule : entrada_jogada
`default_nettype wire

// File: tb/tb_entrada_jogada.sv
`default_nettype none
// ============================================================================
// Module      : tb_entrada_jogada
// Description : Self-checking bench for entrada_jogada with DEBOUNCE_CYCLES=4.
//               Directed scenarios followed by randomized switch entries
//               judged by a digit-histogram reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_entrada_jogada;

    localparam int C_DB      = 4;
    localparam int C_LATENCY = 2 + C_DB + 2;

    logic        clock;
    logic        reset;
    logic        enter_button;
    logic [15:0] SW;
    logic        guess_ready;
    logic        guess_valid;
    logic [15:0] guess;
    logic        guess_err;

    int checks;
    int errors;

    // Monitor state
    int          cyc;
    logic [15:0] xq[$];
    int          n_err;
    int          n_vcyc;
    int          n_both;
    int          v_rise_cyc;
    logic        prev_valid;

    entrada_jogada #(
        .DEBOUNCE_CYCLES (C_DB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enter_button (enter_button),
        .SW           (SW),
        .guess_ready  (guess_ready),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_err    (guess_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        n_err      = 0;
        n_vcyc     = 0;
        n_both     = 0;
        v_rise_cyc = -1;
        prev_valid = 1'b0;
    end

    // Sampled mid-cycle: a transfer is recorded when valid and ready are both
    // high ahead of the rising edge that completes it.
    always @(negedge clock) begin
        if (reset && guess_valid && guess_ready) xq.push_back(guess);
        if (guess_err) n_err++;
        if (guess_valid) n_vcyc++;
        if (guess_valid && guess_err) n_both++;
        if (guess_valid && !prev_valid) v_rise_cyc = cyc;
        prev_valid = guess_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_valid(output logic found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (guess_valid) found = 1'b1;
        end
    endtask

    // Reference rule: every nibble a decimal digit, each digit used once.
    function automatic logic ref_ok(input logic [15:0] v);
        int seen[10];
        int d;
        for (int k = 0; k < 10; k++) seen[k] = 0;
        for (int k = 0; k < 4; k++) begin
            d = int'((v >> (4 * k)) & 16'hF);
            if (d > 9) return 1'b0;
            if (seen[d] != 0) return 1'b0;
            seen[d] = 1;
        end
        return 1'b1;
    endfunction

    initial begin
        int          bx;
        int          be;
        int          bv;
        int          press_cyc;
        logic        found;
        logic [15:0] rv;
        logic [31:0] r32;
        int          used[10];
        int          dg;
        int          dly;

        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        enter_button = 1'b0;
        SW           = 16'h0000;
        guess_ready  = 1'b0;

        // Reset state
        cycles(3);
        check("rst_valid", {31'd0, guess_valid}, 32'd0);
        check("rst_guess", {16'd0, guess}, 32'd0);
        check("rst_err", {31'd0, guess_err}, 32'd0);
        reset = 1'b1;
        cycles(3);

        // 1: clean press, ready high in advance
        SW = 16'h1234; guess_ready = 1'b1;
        cycles(4);
        bx = xq.size(); be = n_err; bv = n_vcyc;
        enter_button = 1'b1; press_cyc = cyc;
        cycles(20);
        enter_button = 1'b0;
        cycles(12);
        check("t1_xfers", xq.size() - bx, 32'd1);
        if (xq.size() > bx) check("t1_value", {16'd0, xq[bx]}, 32'h1234);
        check("t1_vcycles", n_vcyc - bv, 32'd1);
        check("t1_latency", v_rise_cyc - press_cyc, C_LATENCY);
        check("t1_err", n_err - be, 32'd0);

        // 2: bouncing button then steady high
        SW = 16'h0987;
        cycles(4);
        bx = xq.size();
        for (int i = 0; i < 10; i++) begin
            enter_button = ~enter_button;
            cycles(2);
        end
        enter_button = 1'b1;
        cycles(20);
        enter_button = 1'b0;
        cycles(12);
        check("t2_xfers", xq.size() - bx, 32'd1);
        if (xq.size() > bx) check("t2_value", {16'd0, xq[bx]}, 32'h0987);

        // 3: repeated digit, then non-decimal digit
        SW = 16'h1231;
        cycles(4);
        bx = xq.size(); be = n_err;
        enter_button = 1'b1; cycles(12); enter_button = 1'b0; cycles(12);
        check("t3a_err", n_err - be, 32'd1);
        check("t3a_xfers", xq.size() - bx, 32'd0);
        SW = 16'h12A4;
        cycles(4);
        bx = xq.size(); be = n_err;
        enter_button = 1'b1; cycles(12); enter_button = 1'b0; cycles(12);
        check("t3b_err", n_err - be, 32'd1);
        check("t3b_xfers", xq.size() - bx, 32'd0);

        // 4: held offer, switch change and second press ignored
        guess_ready = 1'b0; SW = 16'h1234;
        cycles(4);
        bx = xq.size();
        enter_button = 1'b1;
        wait_valid(found);
        check("t4_wait", {31'd0, found}, 32'd1);
        enter_button = 1'b0;
        cycles(8);
        SW = 16'h5678;
        cycles(3);
        enter_button = 1'b1; cycles(10); enter_button = 1'b0;
        check("t4_hold_valid", {31'd0, guess_valid}, 32'd1);
        check("t4_hold_guess", {16'd0, guess}, 32'h1234);
        check("t4_no_xfer", xq.size() - bx, 32'd0);
        cycles(8);
        guess_ready = 1'b1;
        cycles(3);
        check("t4_xfers", xq.size() - bx, 32'd1);
        if (xq.size() > bx) check("t4_value", {16'd0, xq[bx]}, 32'h1234);
        cycles(20);
        check("t4_xfers_after", xq.size() - bx, 32'd1);

        // 5: reset while offering
        guess_ready = 1'b0; SW = 16'h1234;
        cycles(4);
        bx = xq.size();
        enter_button = 1'b1;
        wait_valid(found);
        check("t5_wait", {31'd0, found}, 32'd1);
        enter_button = 1'b0;
        reset = 1'b0;
        cycles(1);
        check("t5_valid", {31'd0, guess_valid}, 32'd0);
        check("t5_guess", {16'd0, guess}, 32'd0);
        reset = 1'b1;
        bv = n_vcyc;
        cycles(50);
        check("t5_quiet", n_vcyc - bv, 32'd0);
        check("t5_xfers", xq.size() - bx, 32'd0);

        // 6: long hold then a second entry
        guess_ready = 1'b1; SW = 16'h1234;
        cycles(4);
        bx = xq.size();
        enter_button = 1'b1; cycles(40); enter_button = 1'b0; cycles(15);
        SW = 16'h4321; cycles(5);
        enter_button = 1'b1; cycles(10); enter_button = 1'b0; cycles(15);
        check("t6_xfers", xq.size() - bx, 32'd2);
        if (xq.size() >= bx + 2) begin
            check("t6_first", {16'd0, xq[bx]}, 32'h1234);
            check("t6_second", {16'd0, xq[bx+1]}, 32'h4321);
        end

        // Randomized entries
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 10; k++) used[k] = 0;
                rv = 16'h0000;
                for (int k = 0; k < 4; k++) begin
                    dg = int'($urandom_range(0, 9));
                    while (used[dg] != 0) dg = (dg + 1) % 10;
                    used[dg] = 1;
                    rv = (rv << 4) | 16'(dg);
                end
            end else begin
                r32 = $urandom();
                rv  = r32[15:0];
            end
            SW = rv; guess_ready = 1'b0;
            cycles(4);
            bx = xq.size(); be = n_err;
            enter_button = 1'b1;
            if (ref_ok(rv)) begin
                wait_valid(found);
                check("rnd_wait", {31'd0, found}, 32'd1);
                dly = int'($urandom_range(0, 4));
                cycles(dly);
                check("rnd_hold", {16'd0, guess}, {16'd0, rv});
                guess_ready = 1'b1;
                cycles(2);
                enter_button = 1'b0;
                cycles(12);
                check("rnd_xfers", xq.size() - bx, 32'd1);
                if (xq.size() > bx) check("rnd_value", {16'd0, xq[bx]}, {16'd0, rv});
                check("rnd_noerr", n_err - be, 32'd0);
            end else begin
                cycles(12);
                enter_button = 1'b0;
                cycles(12);
                check("rnd_err", n_err - be, 32'd1);
                check("rnd_noxfer", xq.size() - bx, 32'd0);
            end
        end

        check("never_both", n_both, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_entrada_jogada
`default_nettype wire

// File: doc/entrada_jogada.md
Name: entrada_jogada

Overview:
Input front-end for the Bulls-and-Cows game. It synchronizes and debounces enter_button and validates the four switch digits on SW. It then offers one captured guess per press to the game core over a valid/ready handshake. This is the producer of every guess and secret the game logic consumes, the counterpart of the display path that the game drives.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); must be >= 2
CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter (derived, not overridden)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
enter_button  input  1  raw asynchronous push-button
SW  input  16  raw switches; four digits, SW[15:12] is the leftmost digit
guess_ready  input  1  game core can accept a guess
guess_valid  output  1  guess holds a validated value
guess  output  16  captured digits, same layout as SW
guess_err  output  1  one-cycle pulse: rejected entry

Behaviour:
- Reset: reset==0 at a clock edge clears everything. guess_valid=0, guess=16'h0000, guess_err=0, FSM=IDLE, debounced level=0, counter=0, synchronizer flops=0. Reset is honoured in every state.
- Synchronizers: two flops on enter_button and two flops per SW bit. SW is used only after synchronization.
- Debounce (the debouncer sub-module):
  - While the synchronized level equals the stable level, the counter is held at 0.
  - While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears.
  - press = one-cycle pulse on a 0->1 transition of the stable level.
- FSM states: IDLE, CHECK, OFFER, WAIT_RELEASE.
  - IDLE: on press, latch synchronized SW into snap, go to CHECK.
  - CHECK (exactly 1 cycle): the entry is invalid if any nibble > 9 or any two of the four nibbles are equal.
    - Invalid: guess_err=1 for this single cycle, go to WAIT_RELEASE.
    - Valid: guess<=snap, guess_valid<=1, go to OFFER.
  - OFFER: guess_valid and guess stay stable until guess_ready==1. Transfer happens on the edge where valid&&ready. On the next cycle guess_valid=0 and guess keeps its value. Then go to WAIT_RELEASE if the stable level is 1, otherwise IDLE.
  - WAIT_RELEASE: when the stable level is 0, go to IDLE.
- Latency: press pulse at edge N gives guess_valid high after edge N+2. From a clean raw edge, the total is 2 sync + DEBOUNCE_CYCLES + 2 cycles. guess_ready may be high in advance; that gives a 1-cycle valid.
- Boundary rules:
  - Presses during CHECK, OFFER or WAIT_RELEASE are ignored; there is no queue.
  - SW changes after capture do not affect guess.
  - Holding the button gives exactly one transfer.
  - A button held through reset release is debounced from level 0 and counts as one press.
  - Reset during OFFER drops valid with no transfer.
  - guess_ready is ignored outside OFFER.
  - guess_err and guess_valid are never high in the same cycle.

Decomposition:
- Shared package bc_pkg:
  - NUM_DIGITS=4, DIGIT_W=4, MAX_DIGIT=4'd9
  - typedef enum logic [1:0] {IDLE, CHECK, OFFER, WAIT_RELEASE} entrada_state_t
  - typedef logic [NUM_DIGITS*DIGIT_W-1:0] guess_t
- One sub-module, debouncer (parameter DEBOUNCE_CYCLES):
  - inputs: clock, reset, raw
  - outputs: level, rise
  - The debouncer contains the enter_button synchronizer.
- The digit check is a combinational function in bc_pkg, so the game core can reuse it when it validates the secret.

Test Plan:
All cases use DEBOUNCE_CYCLES=4.
1. SW=16'h1234, clean press held 20 cycles, guess_ready=1 -> guess_valid high exactly 1 cycle, 2+4+2 cycles after the raw rise; guess=16'h1234; guess_err never high.
2. enter_button toggles every 2 cycles for 20 cycles, then stays high, SW=16'h0987 -> exactly one transfer, guess=16'h0987.
3. SW=16'h1231, press -> one guess_err pulse, no valid. SW=16'h12A4, press -> one guess_err pulse, no valid.
4. SW=16'h1234, guess_ready=0 for 10 cycles; during OFFER set SW=16'h5678 and press again -> guess holds 16'h1234 until ready=1. One transfer only; the second press is ignored.
5. reset=0 for 1 cycle while in OFFER -> next cycle guess_valid=0, guess=0. With the button released afterwards, no valid for 50 cycles.
6. Button held 40 cycles, released, then pressed again with SW=16'h4321 -> two transfers total, values 16'h1234 then 16'h4321.
